// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex frame accumulator datapath.
package cplx_pkg;

    localparam int PROD_W = 16;

    typedef struct packed {
        logic signed [PROD_W-1:0] re;
        logic signed [PROD_W-1:0] im;
    } cplx16_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/cplx_rnd_sat.sv
// Per-rail round-half-up, arithmetic right shift and width reduction.
// CPLX_ACC_SAT_EN selects clamping with a sat flag; otherwise the result wraps.
module cplx_rnd_sat #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 4,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] res_o,
    output logic                    sat_o
);

    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] HALF = (SHIFT > 0) ? ((ACC_W+1)'(1) << HS) : '0;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    // One guard bit so adding the half-LSB can never overflow.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + HALF;
        return t >>> SHIFT;
    endfunction

    // Returns {sat, value}.
    function automatic logic [OUT_W:0] reduce(input logic signed [ACC_W:0] r);
        logic [OUT_W:0] o;
`ifdef CPLX_ACC_SAT_EN
        if (r > MAXV)      o = {1'b1, MAXV[OUT_W-1:0]};
        else if (r < MINV) o = {1'b1, MINV[OUT_W-1:0]};
        else               o = {1'b0, r[OUT_W-1:0]};
`else
        o = {1'b0, r[OUT_W-1:0]};
`endif
        return o;
    endfunction

    logic [OUT_W:0] red;

    always_comb begin
        red   = reduce(round_shift(acc_i));
        res_o = red[OUT_W-1:0];
        sat_o = red[OUT_W];
    end

endmodule

// File: rtl/cplx_acc.sv
// Complex frame accumulator: sums FRAME_LEN products per rail, then rounds/scales
// and presents one result per frame on valid/ready. Optional clamping: CPLX_ACC_SAT_EN.
module cplx_acc
    import cplx_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 4,
    parameter int OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_re,
    input  logic signed [PROD_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_re,
    output logic signed [OUT_W-1:0]  out_im,
    output logic                     out_sat
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    acc_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic                    out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic signed [OUT_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic                    out_sat_q, out_sat_d;

    cplx16_t                 smp;
    logic signed [ACC_W-1:0] sum_re, sum_im;
    logic signed [OUT_W-1:0] rnd_re, rnd_im;
    logic                    sat_re, sat_im;
    logic                    accept;

    assign smp    = {in_re, in_im};
    assign accept = in_valid && in_ready_q;

    // First sample of a frame loads; later ones add.
    always_comb begin
        sum_re = {{(ACC_W-PROD_W){smp.re[PROD_W-1]}}, smp.re};
        sum_im = {{(ACC_W-PROD_W){smp.im[PROD_W-1]}}, smp.im};
        if (cnt_q != '0) begin
            sum_re = sum_re + acc_re_q;
            sum_im = sum_im + acc_im_q;
        end
    end

    cplx_rnd_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rnd_re (
        .acc_i(sum_re), .res_o(rnd_re), .sat_o(sat_re)
    );

    cplx_rnd_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rnd_im (
        .acc_i(sum_im), .res_o(rnd_im), .sat_o(sat_im)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_sat_d   = out_sat_q;
        if (clr) begin
            state_d     = ACCUM;
            cnt_d       = '0;
            acc_re_d    = '0;
            acc_im_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_re_d = sum_re;
                        acc_im_d = sum_im;
                        if (cnt_q == LAST) begin
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                            out_re_d    = rnd_re;
                            out_im_d    = rnd_im;
                            out_sat_d   = sat_re | sat_im;
                            state_d     = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
        // Registered ready tracks the state being entered, so it stays low through reset.
        in_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cplx_acc.sv
// Scoreboard bench for cplx_acc: two instances (SHIFT=2 and SHIFT=0, FRAME_LEN=4) share stimulus.
module tb_cplx_acc;

    typedef struct {
        int re;
        int im;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;

    logic               a_in_ready, a_out_valid, a_out_sat;
    logic signed [15:0] a_out_re, a_out_im;
    logic               b_in_ready, b_out_valid, b_out_sat;
    logic signed [15:0] b_out_re, b_out_im;

    int total = 0;
    int bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    cplx_acc #(.FRAME_LEN(4), .ACC_W(24), .SHIFT(2), .OUT_W(16)) ua (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_re(a_out_re), .out_im(a_out_im), .out_sat(a_out_sat)
    );

    cplx_acc #(.FRAME_LEN(4), .ACC_W(24), .SHIFT(0), .OUT_W(16)) ub (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_re(b_out_re), .out_im(b_out_im), .out_sat(b_out_sat)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitors: a result is consumed at the edge following a negedge where valid&&ready.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_out_re", int'(a_out_re), e.re);
                check("a_out_im", int'(a_out_im), e.im);
                check("a_out_sat", int'(a_out_sat), e.sat);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_out_re", int'(b_out_re), e.re);
                check("b_out_im", int'(b_out_im), e.im);
                check("b_out_sat", int'(b_out_sat), e.sat);
            end
        end
    end

    task automatic send(input int re, input int im);
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends x,x,y,y; pushes the expected results of both instances when push is set.
    task automatic run_frame(input int xr, input int xi, input int yr, input int yi,
                             input int ar, input int ai, input int br, input int bi,
                             input int bs, input bit push);
        exp_t ea, eb;
        check("in_ready_frame_start", int'(a_in_ready && b_in_ready), 1);
        ea = '{ar, ai, 0};
        eb = '{br, bi, bs};
        if (push) begin
            qa.push_back(ea);
            qb.push_back(eb);
        end
        send(xr, xi);
        send(xr, xi);
        send(yr, yi);
        send(yr, yi);
        check("out_valid_latency", int'(a_out_valid && b_out_valid), 1);
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(a_in_ready), 0);
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_re", int'(a_out_re), 0);
        check("rst_out_im", int'(a_out_im), 0);
        check("rst_out_sat", int'(a_out_sat), 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", int'(a_in_ready), 0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", int'(a_in_ready), 1);

        // Plain frame: sums (400,-200).
        run_frame(100, -50, 100, -50, 100, -50, 400, -200, 0, 1);
        handshake();
        // Rounding: sums (2,-2) -> (1,0) at SHIFT=2.
        run_frame(1, -1, 0, 0, 1, 0, 2, -2, 0, 1);
        handshake();
        // Full-scale: sums (131068,-131072).
`ifdef CPLX_ACC_SAT_EN
        run_frame(32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768, 1, 1);
`else
        run_frame(32767, -32768, 32767, -32768, 32767, -32768, -4, 0, 0, 1);
`endif
        handshake();

        // Backpressure: result held, input pulses ignored.
        out_ready = 1'b0;
        run_frame(7, 3, 7, 3, 7, 3, 28, 12, 0, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_re    = 16'sd1000;
            in_im    = -16'sd1000;
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(a_out_valid && b_out_valid), 1);
            check("bp_a_re_stable", int'(a_out_re), 7);
            check("bp_b_im_stable", int'(b_out_im), 12);
            check("bp_in_ready", int'(a_in_ready || b_in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake();
        run_frame(-3, 5, -3, 5, -3, 5, -12, 20, 0, 1);
        handshake();

        // clr drops the partial frame and the sample presented alongside it.
        send(500, 500);
        send(500, 500);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_re    = 16'sd500;
        in_im    = 16'sd500;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", int'(a_out_valid), 0);
        run_frame(8, 8, 8, 8, 8, 8, 32, 32, 0, 1);
        handshake();

        // Async reset while holding a result.
        out_ready = 1'b0;
        run_frame(2, 2, 2, 2, 2, 2, 8, 8, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("hold_rst_out_valid", int'(a_out_valid || b_out_valid), 0);
        check("hold_rst_a_re", int'(a_out_re), 0);
        check("hold_rst_b_im", int'(b_out_im), 0);
        check("hold_rst_sat", int'(a_out_sat || b_out_sat), 0);
        check("hold_rst_in_ready", int'(a_in_ready), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready_low", int'(a_in_ready), 0);
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", int'(a_in_ready), 1);
        run_frame(-1, 4, -1, 4, -1, 4, -4, 16, 0, 1);
        handshake();

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
